// File: rtl/issue_queue.sv
// In-order issue queue between decode and dual issue: takes up to two entries per cycle and presents the two oldest.
// Optional IQ_BYPASS_EN macro forwards decode straight to issue while the queue is empty.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [1:0]                    push_num,
  input  logic [2*DATA_W-1:0]           push_data,
  output logic                          push_ready,
  output logic [2*DATA_W-1:0]           issue_require,
  output logic [1:0]                    iq_size,
  input  logic [1:0]                    iq_pop_number,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [1:0]        push_n, push_acc, pop_eff, size_c, wr_n, wr_off;
  logic [DATA_W-1:0] push0, push1, req0, req1, wdata0, wdata1;
  logic              byp_c;

  assign push0      = push_data[DATA_W-1:0];
  assign push1      = push_data[2*DATA_W-1:DATA_W];
  // Ready looks only at registered occupancy so decode never waits on issue's pop decision.
  assign push_ready = (count_q <= READY_MAX);

  always_comb begin
    push_n   = (push_num == 2'd3) ? 2'd2 : push_num;
    push_acc = push_ready ? push_n : 2'd0;
    byp_c    = 1'b0;
    size_c   = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    req0     = (count_q != '0)     ? mem_q[head_q] : '0;
    req1     = (count_q >= CW'(2)) ? mem_q[head_q + PW'(1)] : '0;
`ifdef IQ_BYPASS_EN
    if (count_q == '0 && !flush) begin
      byp_c  = 1'b1;
      size_c = push_n;
      req0   = (push_n != 2'd0) ? push0 : '0;
      req1   = (push_n == 2'd2) ? push1 : '0;
    end
`endif
    pop_eff = (iq_pop_number > size_c) ? size_c : iq_pop_number;

    // Bypassed entries that issue takes this cycle never touch storage.
    if (byp_c) begin
      wr_n   = push_acc - pop_eff;
      wr_off = pop_eff;
      head_d = head_q;
    end else begin
      wr_n   = push_acc;
      wr_off = 2'd0;
      head_d = head_q + PW'(pop_eff);
    end
    wdata0  = (wr_off == 2'd0) ? push0 : push1;
    wdata1  = push1;
    tail_d  = tail_q + PW'(wr_n);
    count_d = count_q + CW'(push_acc) - CW'(pop_eff);
  end

  assign issue_require = {req1, req0};
  assign iq_size       = size_c;
  assign count         = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; the read port masks anything beyond count.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr_n != 2'd0) mem_q[tail_q] <= wdata0;
      if (wr_n == 2'd2) mem_q[tail_q + PW'(1)] <= wdata1;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed bench for issue_queue against a queue-based reference model.
module tb_issue_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [1:0]             push_num;
  logic [2*DATA_W-1:0]    push_data;
  logic                   push_ready;
  logic [2*DATA_W-1:0]    issue_require;
  logic [1:0]             iq_size;
  logic [1:0]             iq_pop_number;
  logic [$clog2(DEPTH):0] count;

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_num(push_num), .push_data(push_data), .push_ready(push_ready),
    .issue_require(issue_require), .iq_size(iq_size),
    .iq_pop_number(iq_pop_number), .count(count)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] tag = 16'h0100;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model at the edge.
  task automatic step(input logic fl, input logic [1:0] pn, input logic [1:0] pop);
    int unsigned pe, sz, popn;
    logic [DATA_W-1:0] d0, d1, e0, e1;
    bit byp, rdy;
    @(negedge clk);
    d0 = tag;
    d1 = tag + 16'd1;
    tag = tag + 16'd2;
    flush = fl;
    push_num = pn;
    push_data = {d1, d0};
    iq_pop_number = pop;
    #1;
    pe  = (pn == 2'd3) ? 2 : int'(pn);
    rdy = (DEPTH - mq.size()) >= 2;
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    if (mq.size() == 0 && !fl) byp = 1'b1;
`endif
    if (byp) begin
      sz = pe;
      e0 = (pe >= 1) ? d0 : '0;
      e1 = (pe >= 2) ? d1 : '0;
    end else begin
      sz = (mq.size() >= 2) ? 2 : mq.size();
      e0 = (mq.size() >= 1) ? mq[0] : '0;
      e1 = (mq.size() >= 2) ? mq[1] : '0;
    end
    chk("count",      64'(count),                          64'(mq.size()));
    chk("push_ready", 64'(push_ready),                     64'(rdy));
    chk("iq_size",    64'(iq_size),                        64'(sz));
    chk("req0",       64'(issue_require[DATA_W-1:0]),      64'(e0));
    chk("req1",       64'(issue_require[2*DATA_W-1:DATA_W]), 64'(e1));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy) begin
        if (pe >= 1) mq.push_back(d0);
        if (pe >= 2) mq.push_back(d1);
      end
      popn = (int'(pop) > sz) ? sz : int'(pop);
      repeat (popn) void'(mq.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_num = '0; push_data = '0; iq_pop_number = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();

    // Idle after reset
    repeat (3) step(1'b0, 2'd0, 2'd0);

    // Fill to full, then an offered push while not ready is dropped
    repeat (6) step(1'b0, 2'd2, 2'd0);
    @(negedge clk);
    #1;
    chk("full_count", 64'(count), 64'(DEPTH));

    // Drain, then wrap with push 2 / pop 2
    step(1'b1, 2'd0, 2'd0);
    step(1'b0, 2'd2, 2'd0);
    repeat (20) step(1'b0, 2'd2, 2'd2);
    @(negedge clk);
    #1;
    chk("wrap_count", 64'(count), 64'd2);

    // Over-pop with a single entry
    step(1'b1, 2'd0, 2'd0);
    step(1'b0, 2'd1, 2'd0);
    step(1'b0, 2'd0, 2'd2);
    step(1'b0, 2'd0, 2'd0);

    // Flush with count=5 against a same-cycle push and pop
    step(1'b0, 2'd2, 2'd0);
    step(1'b0, 2'd2, 2'd0);
    step(1'b0, 2'd1, 2'd0);
    step(1'b1, 2'd2, 2'd1);
    step(1'b0, 2'd0, 2'd0);

    // Empty queue: push 2, pop 1 in the same cycle
    step(1'b0, 2'd2, 2'd1);
    step(1'b0, 2'd0, 2'd0);

    // push_num=3 behaves like 2
    step(1'b1, 2'd0, 2'd0);
    step(1'b0, 2'd3, 2'd0);
    step(1'b0, 2'd0, 2'd0);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      logic [1:0] pn, pp;
      fl = ($urandom_range(0, 63) == 0);
      pn = 2'($urandom_range(0, 3));
      pp = ((i / 64) % 2 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      step(fl, pn, pp);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
